// File: rtl/da_pkg.sv
// Shared definitions for the distributed-arithmetic FIR engine: FSM encodings,
// derived-width helpers and packed-bus indexing.
package da_pkg;

    typedef logic [1:0] da_state_t;

    localparam da_state_t ST_IDLE = 2'd0;
    localparam da_state_t ST_RUN  = 2'd1;
    localparam da_state_t ST_DONE = 2'd2;

    function automatic int calc_yw(input int xw, input int ww, input int ntap);
        return xw + ww + $clog2(ntap);
    endfunction

    function automatic int calc_p(input int xw, input int bpc);
        return xw / bpc;
    endfunction

    function automatic int bus_lsb(input int k, input int width);
        return k * width;
    endfunction

endpackage

// File: rtl/da_lut.sv
// Combinational weight-sum table for one input bit-slice. Plain mode sums the weights
// of taps whose bit is set; offset-binary mode forms w0 +/- w[k] keyed by bit[k]^bit[0].
module da_lut
    import da_pkg::*;
#(
    parameter int NTAP = 4,
    parameter int WW   = 10,
    parameter int LW   = 13,
    parameter bit OBC  = 1'b0
) (
    input  logic [NTAP-1:0]      i_bits,
    input  logic [NTAP*WW-1:0]   i_w,
    output logic signed [LW-1:0] o_sum
);

    logic signed [LW-1:0] w_term [NTAP];

    for (genvar k = 0; k < NTAP; k++) begin : g_tap
        logic signed [LW-1:0] w_wx;
        logic                 w_flip;

        assign w_wx   = {{(LW-WW){i_w[bus_lsb(k, WW)+WW-1]}}, i_w[bus_lsb(k, WW) +: WW]};
        // Tap 0 is the reference in offset-binary mode and is never flipped.
        assign w_flip = (k != 0) && (i_bits[k] ^ i_bits[0]);
        assign w_term[k] = OBC ? (w_flip ? -w_wx : w_wx)
                               : (i_bits[k] ? w_wx : '0);
    end

    always_comb begin
        o_sum = '0;
        for (int k = 0; k < NTAP; k++) begin
            o_sum = o_sum + w_term[k];
        end
    end

endmodule

// File: rtl/da_fir_engine.sv
// Bit-serial DA dot-product engine, BPC input bits per clock, start/done handshake.
// Define DA_FIR_OBC_EN to build the offset-binary-coded LUT variant (same y and timing).
module da_fir_engine
    import da_pkg::*;
#(
    parameter int  NTAP = 4,
    parameter int  XW   = 8,
    parameter int  WW   = 10,
    parameter int  BPC  = 2,
    localparam int YW   = calc_yw(XW, WW, NTAP)
) (
    input  logic                 clk,
    input  logic                 r,
    input  logic                 start,
    input  logic [NTAP*XW-1:0]   x,
    input  logic [NTAP*WW-1:0]   w,
    output logic                 busy,
    output logic                 done,
    output logic signed [YW-1:0] y
);

    localparam int P  = calc_p(XW, BPC);
    localparam int CW = (P > 1) ? $clog2(P) : 1;
    localparam int BW = $clog2(XW) + 1;
    localparam int LW = WW + $clog2(NTAP) + 1;
    localparam int AW = YW + 2;

`ifdef DA_FIR_OBC_EN
    localparam bit OBC = 1'b1;
`else
    localparam bit OBC = 1'b0;
`endif

    da_state_t            r_state;
    logic [CW-1:0]        r_cnt;
    logic [NTAP*XW-1:0]   r_x;
    logic [NTAP*WW-1:0]   r_w;
    logic signed [AW-1:0] r_acc;
    logic signed [YW-1:0] r_y;

    logic [BW-1:0]                 w_base;
    logic [BPC-1:0][NTAP-1:0]      w_bits;
    logic signed [AW-1:0]          w_shf [BPC];
    logic signed [AW-1:0]          w_wext [NTAP];
    logic signed [AW-1:0]          w_wsum;
    logic signed [AW-1:0]          w_preload;
    logic signed [AW-1:0]          w_acc_nxt;
    logic signed [AW-1:0]          w_y_src;

    assign w_base = BW'(r_cnt) * BW'(BPC);

    for (genvar k = 0; k < NTAP; k++) begin : g_tap
        logic [XW-1:0] w_xs;

        assign w_xs = r_x[bus_lsb(k, XW) +: XW] >> w_base;
        for (genvar j = 0; j < BPC; j++) begin : g_bit
            assign w_bits[j][k] = w_xs[j];
        end
        assign w_wext[k] = {{(AW-WW){w[bus_lsb(k, WW)+WW-1]}}, w[bus_lsb(k, WW) +: WW]};
    end

    for (genvar j = 0; j < BPC; j++) begin : g_slice
        logic                 w_sgn;
        logic                 w_neg;
        logic signed [LW-1:0] w_lut;
        logic signed [AW-1:0] w_ext;

        da_lut #(
            .NTAP (NTAP),
            .WW   (WW),
            .LW   (LW),
            .OBC  (OBC)
        ) u_lut (
            .i_bits (w_bits[j]),
            .i_w    (r_w),
            .o_sum  (w_lut)
        );

        assign w_sgn = (w_base + BW'(j)) == BW'(XW - 1);
        // OBC: tap 0's bit picks the sign, and the MSB weight flips it once more.
        assign w_neg = OBC ? ~(w_bits[j][0] ^ w_sgn) : w_sgn;
        assign w_ext = {{(AW-LW){w_lut[LW-1]}}, w_lut};
        assign w_shf[j] = (w_neg ? -w_ext : w_ext) <<< (w_base + BW'(j));
    end

    always_comb begin
        w_wsum = '0;
        for (int k = 0; k < NTAP; k++) begin
            w_wsum = w_wsum + w_wext[k];
        end
    end

    always_comb begin
        w_acc_nxt = r_acc;
        for (int j = 0; j < BPC; j++) begin
            w_acc_nxt = w_acc_nxt + w_shf[j];
        end
    end

    // OBC accumulates 2*y starting from -sum(w); the final halving is exact.
    assign w_preload = OBC ? -w_wsum : '0;
    assign w_y_src   = OBC ? (w_acc_nxt >>> 1) : w_acc_nxt;

    always_ff @(posedge clk) begin
        if (r) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_x     <= '0;
            r_w     <= '0;
            r_acc   <= '0;
            r_y     <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_x     <= x;
                        r_w     <= w;
                        r_acc   <= w_preload;
                        r_cnt   <= '0;
                        r_state <= ST_RUN;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    r_acc <= w_acc_nxt;
                    if (r_cnt == CW'(P - 1)) begin
                        r_y     <= YW'(w_y_src);
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (r_state == ST_RUN);
    assign done = (r_state == ST_DONE);
    assign y    = r_y;

endmodule

// File: tb/tb_da_fir_engine.sv
// Directed bench for da_fir_engine: table of hand-computed dot products plus
// reset, ignored-start and back-to-back sequences on BPC=1/2/4 instances.
module tb_da_fir_engine;

    localparam int YW = 20;

    typedef struct {
        string       name;
        logic [31:0] x;
        logic [39:0] w;
        int          y;
    } vec_t;

    logic        clk = 1'b0;
    logic        r;
    logic [31:0] x;
    logic [39:0] w;
    logic        start_b [3];
    logic        busy_b  [3];
    logic        done_b  [3];
    logic [YW-1:0] y_b   [3];

    int   n_chk  = 0;
    int   n_fail = 0;
    vec_t vecs [9];

    always #5 clk = ~clk;

    da_fir_engine #(.NTAP(4), .XW(8), .WW(10), .BPC(1)) u_dut_b1 (
        .clk(clk), .r(r), .start(start_b[0]), .x(x), .w(w),
        .busy(busy_b[0]), .done(done_b[0]), .y(y_b[0])
    );
    da_fir_engine #(.NTAP(4), .XW(8), .WW(10), .BPC(2)) u_dut_b2 (
        .clk(clk), .r(r), .start(start_b[1]), .x(x), .w(w),
        .busy(busy_b[1]), .done(done_b[1]), .y(y_b[1])
    );
    da_fir_engine #(.NTAP(4), .XW(8), .WW(10), .BPC(4)) u_dut_b4 (
        .clk(clk), .r(r), .start(start_b[2]), .x(x), .w(w),
        .busy(busy_b[2]), .done(done_b[2]), .y(y_b[2])
    );

    function automatic logic [31:0] px(input int a0, input int a1, input int a2, input int a3);
        return {a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
    endfunction

    function automatic logic [39:0] pw(input int a0, input int a1, input int a2, input int a3);
        return {a3[9:0], a2[9:0], a1[9:0], a0[9:0]};
    endfunction

    function automatic longint ys(input int d);
        return longint'($signed(y_b[d]));
    endfunction

    task automatic chk(input string nm, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    // One start pulse, then latency, busy span, result and done pulse width.
    task automatic run_one(input int d, input int p, input vec_t v);
        int cyc;
        int bc;
        @(negedge clk);
        x = v.x;
        w = v.w;
        start_b[d] = 1'b1;
        @(negedge clk);
        start_b[d] = 1'b0;
        cyc = 0;
        bc  = 0;
        while (!done_b[d] && cyc < 40) begin
            if (busy_b[d]) bc++;
            @(negedge clk);
            cyc++;
        end
        chk({v.name, " latency"}, cyc, p);
        chk({v.name, " busy cycles"}, bc, p);
        chk({v.name, " y"}, ys(d), v.y);
        chk({v.name, " busy at done"}, busy_b[d], 0);
        @(negedge clk);
        chk({v.name, " done width"}, done_b[d], 0);
        chk({v.name, " y held"}, ys(d), v.y);
    endtask

    task automatic count_dones(input int d, input int ncyc, output int n);
        n = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (done_b[d]) n++;
        end
    endtask

    // start held high; operands swapped right after each capture.
    task automatic b2b(input int d, input int p, input string nm);
        int t;
        int last;
        int wc;
        int sel [2];
        sel[0] = 2;
        sel[1] = 3;
        @(negedge clk);
        x = vecs[sel[0]].x;
        w = vecs[sel[0]].w;
        start_b[d] = 1'b1;
        @(negedge clk);
        x = vecs[sel[1]].x;
        w = vecs[sel[1]].w;
        t    = 0;
        last = 0;
        for (int k = 0; k < 4; k++) begin
            wc = 0;
            while (!done_b[d] && wc < 30) begin
                @(negedge clk);
                t++;
                wc++;
            end
            chk($sformatf("%s job%0d y", nm, k), ys(d), vecs[sel[k%2]].y);
            if (k == 0) chk($sformatf("%s first latency", nm), t, p);
            else        chk($sformatf("%s period%0d", nm, k), t - last, p + 1);
            last = t;
            @(negedge clk);
            t++;
            x = vecs[sel[k%2]].x;
            w = vecs[sel[k%2]].w;
        end
        start_b[d] = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int cyc;

        vecs[0] = '{"basic",    px(1, 2, 3, 4),           pw(1, 1, 1, 1),           10};
        vecs[1] = '{"min_min",  px(-128, -128, -128, -128), pw(-512, -512, -512, -512), 262144};
        vecs[2] = '{"mixed",    px(-128, 127, 0, -1),     pw(511, -512, 3, 7),      -130439};
        vecs[3] = '{"signs",    px(5, -3, 100, -77),      pw(-200, 300, -1, 0),     -2000};
        vecs[4] = '{"max_max",  px(127, 127, 127, 127),   pw(511, 511, 511, 511),   259588};
        vecs[5] = '{"min_max",  px(-128, -128, -128, -128), pw(511, 511, 511, 511), -261632};
        vecs[6] = '{"zero_x",   px(0, 0, 0, 0),           pw(511, -512, 3, 7),      0};
        vecs[7] = '{"one_tap",  px(1, 0, 0, 0),           pw(-512, 0, 0, 0),        -512};
        vecs[8] = '{"max_min",  px(127, 127, 127, 127),   pw(-512, -512, -512, -512), -260096};

        r = 1'b1;
        x = '0;
        w = '0;
        for (int d = 0; d < 3; d++) start_b[d] = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset busy d%0d", d), busy_b[d], 0);
            chk($sformatf("reset done d%0d", d), done_b[d], 0);
            chk($sformatf("reset y d%0d", d), ys(d), 0);
        end
        r = 1'b0;

        for (int i = 0; i < 9; i++) run_one(1, 4, vecs[i]);

        // start during RUN with new operands must neither disturb nor queue.
        @(negedge clk);
        x = vecs[2].x;
        w = vecs[2].w;
        start_b[1] = 1'b1;
        @(negedge clk);
        start_b[1] = 1'b0;
        @(negedge clk);
        x = vecs[3].x;
        w = vecs[3].w;
        start_b[1] = 1'b1;
        @(negedge clk);
        start_b[1] = 1'b0;
        cyc = 2;
        while (!done_b[1] && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("ignored start latency", cyc, 4);
        chk("ignored start y", ys(1), vecs[2].y);
        count_dones(1, 12, n);
        chk("ignored start not queued", n, 0);
        run_one(1, 4, vecs[3]);

        // Synchronous reset two cycles into RUN discards the job.
        @(negedge clk);
        x = vecs[4].x;
        w = vecs[4].w;
        start_b[1] = 1'b1;
        @(negedge clk);
        start_b[1] = 1'b0;
        @(negedge clk);
        r = 1'b1;
        @(negedge clk);
        r = 1'b0;
        chk("mid-run reset busy", busy_b[1], 0);
        chk("mid-run reset done", done_b[1], 0);
        chk("mid-run reset y", ys(1), 0);
        count_dones(1, 10, n);
        chk("mid-run reset no done", n, 0);
        run_one(1, 4, vecs[5]);

        b2b(1, 4, "b2b bpc2");
        b2b(0, 8, "b2b bpc1");
        b2b(2, 2, "b2b bpc4");
        run_one(0, 8, vecs[2]);
        run_one(2, 2, vecs[8]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
